// File: rtl/shiftable_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shiftable_memory_ctrl
// Description : Stream-side sequencer for a shiftable_memory. Fills bank B
//               from an input stream, swaps the full frame into bank A with
//               one shift+clear, and drains bank A to an output stream.
//               The single memory address port alternates between write
//               slots (slot=0) and read slots (slot=1).
// Revision    : 1.0 - initial release
// ============================================================================
module shiftable_memory_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_CAPACITY = 49,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WDB,
  output logic                  mem_WEB,
  output logic                  mem_shiftA,
  output logic                  mem_clrB,
  input  logic [DATA_WIDTH-1:0] mem_RDA
);

  // One spare bit so the read counter can reach MEM_CAPACITY even when
  // MEM_CAPACITY == 2**ADDR_WIDTH.
  localparam int                c_cnt_w = ADDR_WIDTH + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MEM_CAPACITY - 1);
  localparam logic [c_cnt_w-1:0] c_cap  = c_cnt_w'(MEM_CAPACITY);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  typedef enum logic [0:0] {
    W_FILL = 1'b0,
    W_FULL = 1'b1
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rstate_t;

  wstate_t                r_wstate;
  rstate_t                r_rstate;
  logic                   r_slot;
  logic [c_cnt_w-1:0]     r_wr_cnt;
  logic [c_cnt_w-1:0]     r_rd_cnt;
  logic                   r_rd_pend;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic                   r_out_last;
  logic [ADDR_WIDTH-1:0]  r_mem_a;
  logic [DATA_WIDTH-1:0]  r_mem_wdb;
  logic                   r_mem_web;
  logic                   r_mem_shift;
  logic                   r_mem_clr;

  logic w_in_ready;
  logic w_wr_fire;
  logic w_swap;
  logic w_out_fire;
  logic w_rd_issue;

  // Input is accepted only in write slots while filling; held low in reset
  // so every output reads 0 while rst is asserted.
  assign w_in_ready = !rst && !r_slot && (r_wstate == W_FILL);
  assign w_wr_fire  = in_valid && w_in_ready;
  // A full bank B moves to bank A as soon as the reader has finished.
  assign w_swap     = (r_wstate == W_FULL) && (r_rstate == R_IDLE);
  assign w_out_fire = r_out_valid && out_ready;
  // Reads go out in read slots, one outstanding at a time, only when the
  // output register will be free by the time the data is captured.
  assign w_rd_issue = (r_rstate == R_DRAIN) && r_slot && !r_rd_pend &&
                      (r_rd_cnt < c_cap) && (!r_out_valid || out_ready);

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign mem_A      = r_mem_a;
  assign mem_WDB    = r_mem_wdb;
  assign mem_WEB    = r_mem_web;
  assign mem_shiftA = r_mem_shift;
  assign mem_clrB   = r_mem_clr;

  // Slot toggle, write/read state machines and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot      <= 1'b0;
      r_wstate    <= W_FILL;
      r_rstate    <= R_IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_rd_pend   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_mem_a     <= '0;
      r_mem_wdb   <= '0;
      r_mem_web   <= 1'b0;
      r_mem_shift <= 1'b0;
      r_mem_clr   <= 1'b0;
    end else begin
      r_slot      <= ~r_slot;
      r_mem_web   <= 1'b0;
      r_mem_shift <= 1'b0;
      r_mem_clr   <= 1'b0;

      // Write side: one sample per write slot into bank B.
      if (w_wr_fire) begin
        r_mem_a   <= r_wr_cnt[ADDR_WIDTH-1:0];
        r_mem_wdb <= in_data;
        r_mem_web <= 1'b1;
        if (r_wr_cnt == c_last) begin
          r_wr_cnt <= '0;
          r_wstate <= W_FULL;
        end else begin
          r_wr_cnt <= r_wr_cnt + c_one;
        end
      end

      // Swap: only reachable from W_FULL, so never coincides with a write.
      if (w_swap) begin
        r_mem_shift <= 1'b1;
        r_mem_clr   <= 1'b1;
        r_wstate    <= W_FILL;
        r_rstate    <= R_DRAIN;
        r_rd_cnt    <= '0;
      end

      // Read issue: slot=1 only, so never on the same edge as a write.
      if (w_rd_issue) begin
        r_mem_a   <= r_rd_cnt[ADDR_WIDTH-1:0];
        r_rd_pend <= 1'b1;
      end

      // Capture one edge after issue; mem_RDA settled on the falling edge.
      if (r_rd_pend) begin
        r_out_data  <= mem_RDA;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_rd_cnt == c_last);
        r_rd_pend   <= 1'b0;
        r_rd_cnt    <= r_rd_cnt + c_one;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        if (r_out_last) begin
          r_rstate <= R_IDLE;
        end
      end
    end
  end

endmodule
`default_nettype wire
